// File: rtl/vend_pkg.sv
// vend_pkg: drink codes, prices, coin values and status/state enums shared with the vending FSM
package vend_pkg;

    localparam logic [1:0] DRINK_NONE  = 2'b00;
    localparam logic [1:0] DRINK_WATER = 2'b01;
    localparam logic [1:0] DRINK_SODA  = 2'b11;

    localparam int PRICE_WATER = 30;
    localparam int PRICE_SODA  = 50;

    // Legal coins, largest first
    localparam int NUM_COINS = 5;
    localparam int COIN_VAL [NUM_COINS] = '{200, 100, 50, 20, 10};

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_TIMEOUT  = 2'd1,
        ST_REJECTED = 2'd2,
        ST_MISMATCH = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        IDLE, CHECK, INSERT, GAP, PRESS, WAIT_BEV, WAIT_CHG, DONE
    } state_t;

    function automatic logic drink_ok(input logic [1:0] drink);
        return drink == DRINK_WATER || drink == DRINK_SODA;
    endfunction

    function automatic int price(input logic [1:0] drink);
        return drink == DRINK_SODA ? PRICE_SODA : PRICE_WATER;
    endfunction

endpackage

// File: rtl/vend_order_driver_if.sv
// vend_order_driver_if: order handshake, FSM-side coin/button/result wires and completion record
interface vend_order_driver_if #(parameter int W = 16);

    logic         order_valid;
    logic         order_ready;
    logic [1:0]   order_drink;
    logic [W-1:0] order_amount;
    logic [W-1:0] coin_in;
    logic [1:0]   button_in;
    logic [1:0]   beverage_out;
    logic [W-1:0] change_out;
    logic         done_valid;
    logic [1:0]   done_status;
    logic [1:0]   done_beverage;
    logic [W-1:0] done_change;

    // master: the order driver; slave: host plus vending FSM
    modport master (
        input  order_valid, order_drink, order_amount, beverage_out, change_out,
        output order_ready, coin_in, button_in,
               done_valid, done_status, done_beverage, done_change
    );

    modport slave (
        output order_valid, order_drink, order_amount, beverage_out, change_out,
        input  order_ready, coin_in, button_in,
               done_valid, done_status, done_beverage, done_change
    );

endinterface

// File: rtl/vend_coin_select.sv
// vend_coin_select: greedy largest legal coin not exceeding the remaining amount
module vend_coin_select
    import vend_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] remaining,
    output logic [W-1:0] coin,
    output logic [W-1:0] remaining_next
);

    // Scan smallest to largest so the largest fitting coin wins
    always_comb begin
        coin = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--)
            if (remaining >= W'(COIN_VAL[i])) coin = W'(COIN_VAL[i]);
    end

    assign remaining_next = remaining - coin;

endmodule

// File: rtl/vend_order_driver.sv
// vend_order_driver: plays one purchase order into the vending FSM and reports the outcome
module vend_order_driver
    import vend_pkg::*;
#(
    parameter int W        = 16,
    parameter int BEV_WAIT = 8,
    parameter int CHG_WAIT = 6
) (
    input logic                 clk,
    input logic                 rst,
    vend_order_driver_if.master bus
);

    localparam int CW = $clog2((BEV_WAIT > CHG_WAIT) ? BEV_WAIT : CHG_WAIT) + 1;

    state_t       state;
    logic [1:0]   drink;
    logic [W-1:0] amount;
    logic [W-1:0] remaining;
    logic [W-1:0] sel_in;
    logic [W-1:0] coin;
    logic [W-1:0] remaining_next;
    logic [CW-1:0] cnt;
    logic         reject;
    logic         fin;
    status_t      fin_status;
    logic [1:0]   fin_bev;
    logic [W-1:0] fin_chg;

    // The first coin is chosen from the latched amount while still in CHECK
    assign sel_in = (state == CHECK) ? amount : remaining;

    vend_coin_select #(.W(W)) u_coin_select (
        .remaining      (sel_in),
        .coin           (coin),
        .remaining_next (remaining_next)
    );

    assign reject = !drink_ok(drink) || (amount % W'(10)) != '0 || amount == '0 ||
                    amount < W'(price(drink));

    // Completion decision: which states finish this cycle and with what record.
    // The press cycle counts as cycle 0, so a timeout lands BEV_WAIT cycles after it.
    always_comb begin
        fin        = 1'b0;
        fin_status = ST_OK;
        fin_bev    = DRINK_NONE;
        fin_chg    = '0;
        case (state)
            CHECK: begin
                fin        = reject;
                fin_status = ST_REJECTED;
            end
            WAIT_BEV: begin
                if (bus.beverage_out == drink) begin
                    fin     = bus.change_out != '0;
                    fin_bev = drink;
                    fin_chg = bus.change_out;
                end else if (bus.beverage_out != DRINK_NONE) begin
                    fin        = 1'b1;
                    fin_status = ST_MISMATCH;
                    fin_bev    = bus.beverage_out;
                end else if (cnt == CW'(BEV_WAIT - 1)) begin
                    fin        = 1'b1;
                    fin_status = ST_TIMEOUT;
                end
            end
            WAIT_CHG: begin
                fin     = bus.change_out != '0 || cnt == CW'(CHG_WAIT - 1);
                fin_bev = drink;
                fin_chg = bus.change_out;
            end
            default: ;
        endcase
    end

    // Order sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            drink             <= DRINK_NONE;
            amount            <= '0;
            remaining         <= '0;
            cnt               <= '0;
            bus.order_ready   <= 1'b1;
            bus.coin_in       <= '0;
            bus.button_in     <= DRINK_NONE;
            bus.done_valid    <= 1'b0;
            bus.done_status   <= ST_OK;
            bus.done_beverage <= DRINK_NONE;
            bus.done_change   <= '0;
        end else begin
            bus.done_valid <= fin;
            if (fin) begin
                state             <= DONE;
                bus.done_status   <= fin_status;
                bus.done_beverage <= fin_bev;
                bus.done_change   <= fin_chg;
            end else begin
                case (state)
                    IDLE: if (bus.order_valid) begin
                        drink           <= bus.order_drink;
                        amount          <= bus.order_amount;
                        bus.order_ready <= 1'b0;
                        state           <= CHECK;
                    end
                    CHECK: begin
                        bus.coin_in <= coin;
                        remaining   <= remaining_next;
                        state       <= INSERT;
                    end
                    INSERT: begin
                        bus.coin_in <= coin;
                        remaining   <= remaining_next;
                        state       <= (remaining == '0) ? GAP : INSERT;
                    end
                    GAP: begin
                        bus.button_in <= drink;
                        state         <= PRESS;
                    end
                    PRESS: begin
                        bus.button_in <= DRINK_NONE;
                        cnt           <= CW'(1);
                        state         <= WAIT_BEV;
                    end
                    WAIT_BEV: begin
                        cnt   <= (bus.beverage_out == drink) ? '0 : cnt + 1'b1;
                        state <= (bus.beverage_out == drink) ? WAIT_CHG : WAIT_BEV;
                    end
                    WAIT_CHG: cnt <= cnt + 1'b1;
                    DONE: begin
                        bus.order_ready <= 1'b1;
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vend_order_driver.sv
// tb_vend_order_driver: randomized orders against a cycle-numbered outcome model with an FSM stub
module tb_vend_order_driver;

    localparam int W      = 16;
    localparam int BW     = 8;
    localparam int CWT    = 6;
    localparam int NEVER  = 0;
    localparam int NORMAL = 1;
    localparam int WRONG  = 2;
    localparam int LATE   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vend_order_driver_if #(.W(W)) bus ();

    vend_order_driver #(.W(W), .BEV_WAIT(BW), .CHG_WAIT(CWT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Issues one order at a negedge and follows it cycle by cycle until done.
    // Cycle k=1 is the first cycle after the accepting edge. The FSM stub shows
    // the beverage db cycles after the press and the change dc cycles after that.
    task automatic run_order(input logic [1:0] d, input int amt, input int mode,
                             input int db_in, input int dc, input bit hold);
        int cv [5] = '{200, 100, 50, 20, 10};
        int coins[$];
        int rem, pr, ch, kp, kb, kd, db, e_chg, n;
        logic rej;
        logic [1:0] e_st, e_bev, bev_drv;
        logic [31:0] ec, eb;
        bit seen;
        bus.order_drink  = d;
        bus.order_amount = W'(amt);
        bus.order_valid  = 1'b1;
        n = 0;
        while (!bus.order_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.order_ready), 1);
        pr  = (d == 2'b11) ? 50 : 30;
        rej = !(d == 2'b01 || d == 2'b11) || (amt % 10) != 0 || amt == 0 || amt < pr;
        rem = amt;
        if (!rej)
            while (rem > 0)
                for (int i = 0; i < 5; i++)
                    if (cv[i] <= rem) begin
                        coins.push_back(cv[i]);
                        rem -= cv[i];
                        break;
                    end
        ch      = amt - pr;
        db      = (mode == LATE) ? BW : db_in;
        kp      = coins.size() + 3;
        kb      = kp + db;
        bev_drv = (mode == WRONG) ? ((d == 2'b01) ? 2'b11 : 2'b01) : d;
        e_chg   = 0;
        e_bev   = 2'b00;
        if (rej) begin
            kd   = 2;
            e_st = 2'd2;
        end else if (mode == NEVER || mode == LATE) begin
            kd   = kp + BW;
            e_st = 2'd1;
        end else if (mode == WRONG) begin
            kd    = kb + 1;
            e_st  = 2'd3;
            e_bev = bev_drv;
        end else begin
            e_st  = 2'd0;
            e_bev = d;
            if (ch != 0 && dc <= CWT) begin
                kd    = kb + dc + 1;
                e_chg = ch;
            end else kd = kb + CWT + 1;
        end
        seen = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) bus.order_valid = 1'b0;
            ec = 0;
            if (!rej && k >= 2 && k - 2 < coins.size()) ec = 32'(coins[k - 2]);
            eb = (!rej && k == kp) ? 32'(d) : 0;
            check("coin", 32'(bus.coin_in), ec);
            check("button", 32'(bus.button_in), eb);
            check("ready_busy", 32'(bus.order_ready), 0);
            if (bus.done_valid) begin
                seen = 1'b1;
                check("done_cycle", 32'(k), 32'(kd));
                check("status", 32'(bus.done_status), 32'(e_st));
                check("beverage", 32'(bus.done_beverage), 32'(e_bev));
                check("change", 32'(bus.done_change), 32'(e_chg));
                break;
            end
            bus.beverage_out = (!rej && mode != NEVER && k == kb) ? bev_drv : 2'b00;
            bus.change_out   = (!rej && mode == NORMAL && ch != 0 && k == kb + dc) ? W'(ch) : '0;
        end
        if (!seen) check("done_seen", 0, 1);
        @(negedge clk);
        bus.beverage_out = 2'b00;
        bus.change_out   = '0;
        check("done_pulse", 32'(bus.done_valid), 0);
        check("ready_idle", 32'(bus.order_ready), 1);
        check("status_hold", 32'(bus.done_status), 32'(e_st));
        check("change_hold", 32'(bus.done_change), 32'(e_chg));
    endtask

    initial begin
        int any_done;
        int r, amt, md;
        logic [1:0] dr;
        bus.order_valid  = 1'b0;
        bus.order_drink  = 2'b00;
        bus.order_amount = '0;
        bus.beverage_out = 2'b00;
        bus.change_out   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.order_ready), 1);
        check("rst_coin", 32'(bus.coin_in), 0);
        check("rst_button", 32'(bus.button_in), 0);
        check("rst_done", 32'(bus.done_valid), 0);
        check("rst_status", 32'(bus.done_status), 0);
        rst = 1'b1;
        @(negedge clk);

        run_order(2'b01, 30, NORMAL, 2, 0, 0);
        run_order(2'b11, 70, NORMAL, 1, 2, 0);
        run_order(2'b01, 25, NORMAL, 1, 0, 0);
        run_order(2'b11, 40, NORMAL, 1, 0, 0);
        run_order(2'b01, 30, NEVER, 0, 0, 0);
        run_order(2'b11, 50, LATE, 0, 0, 0);
        run_order(2'b01, 40, WRONG, 3, 0, 0);
        run_order(2'b11, 100, NORMAL, 2, 0, 0);
        run_order(2'b11, 60, NORMAL, 1, CWT, 0);
        run_order(2'b11, 60, NORMAL, 1, CWT + 1, 0);
        run_order(2'b10, 100, NORMAL, 1, 0, 0);
        run_order(2'b01, 0, NORMAL, 1, 0, 0);

        // Reset in the middle of coin insertion
        bus.order_drink  = 2'b11;
        bus.order_amount = W'(380);
        bus.order_valid  = 1'b1;
        @(negedge clk);
        bus.order_valid = 1'b0;
        @(negedge clk);
        check("abort_coin1", 32'(bus.coin_in), 200);
        @(negedge clk);
        check("abort_coin2", 32'(bus.coin_in), 100);
        rst = 1'b0;
        #1;
        check("abort_coin_zero", 32'(bus.coin_in), 0);
        check("abort_ready", 32'(bus.order_ready), 1);
        check("abort_button", 32'(bus.button_in), 0);
        @(negedge clk);
        rst = 1'b1;
        any_done = 0;
        repeat (15) begin
            @(negedge clk);
            any_done += int'(bus.done_valid);
        end
        check("abort_no_done", 32'(any_done), 0);
        run_order(2'b01, 30, NORMAL, 1, 0, 0);

        // order_valid held across back-to-back orders
        run_order(2'b01, 30, NORMAL, 1, 0, 1);
        run_order(2'b11, 70, NORMAL, 1, 1, 1);
        run_order(2'b01, 40, NORMAL, 2, 1, 0);

        for (int t = 0; t < 40; t++) begin
            r   = $urandom_range(0, 9);
            dr  = (r < 4) ? 2'b01 : (r < 8) ? 2'b11 : (r == 8) ? 2'b00 : 2'b10;
            amt = ($urandom_range(0, 4) != 0) ? 10 * $urandom_range(0, 40) : $urandom_range(0, 400);
            md  = $urandom_range(0, 3);
            run_order(dr, amt, md, $urandom_range(1, BW - 1), $urandom_range(0, CWT + 2),
                      1'($urandom_range(0, 1)));
        end
        bus.order_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
